// File: rtl/hs_skid_slice.sv
// Two-entry valid/ready skid slice with a beat counter; both s_ready and m_valid
// come straight from flops so neither handshake path crosses the slice combinationally.
module hs_skid_slice #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 3,
  parameter bit          CNT_SAT = 1'b0
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  beat_cnt
);

  // A beat moves on an edge where valid and ready are both high; a producer
  // holds valid and data steady until that edge, and ready never waits on valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   head_q, head_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push;
  logic                pop;

  assign push = s_valid & s_ready_q;
  assign pop  = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          head_d  = s_data;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_d = ST_FULL;
          skid_d  = s_data;
        end else if (!push && pop) begin
          state_d = ST_EMPTY;
        end else if (push && pop) begin
          head_d  = s_data;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake flags are precomputed from the next state to stay registered.
    m_valid_d = (state_d != ST_EMPTY);
    s_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (pop) begin
      if (CNT_SAT && (cnt_q == {CNT_W{1'b1}})) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      cnt_q     <= cnt_d;
    end
  end

  // Payload storage needs no reset: its contents only matter while marked valid.
  always_ff @(posedge sys_clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = head_q;
  assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_hs_skid_slice.sv
// Bench for hs_skid_slice: per-cycle vector table on an 8-bit wrap/saturate pair,
// then a long random valid/ready run on a 32-bit slice, all backed by scoreboards.
module tb_hs_skid_slice;

  // ---------------- clock / reset ----------------
  logic sys_clk;
  logic rst;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- DUT signals ----------------
  logic        s_valid, s_ready, m_valid, m_ready, cnt_clr;
  logic [7:0]  s_data, m_data;
  logic [2:0]  beat_cnt;
  logic        sat_s_ready, sat_m_valid;
  logic [7:0]  sat_m_data;
  logic [2:0]  sat_beat_cnt;

  logic        r_s_valid, r_s_ready, r_m_valid, r_m_ready, r_cnt_clr;
  logic [31:0] r_s_data, r_m_data;
  logic [15:0] r_beat_cnt;

  hs_skid_slice #(.DATA_W(8), .CNT_W(3), .CNT_SAT(1'b0)) u_wrap (
    .sys_clk(sys_clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cnt_clr(cnt_clr), .beat_cnt(beat_cnt)
  );

  hs_skid_slice #(.DATA_W(8), .CNT_W(3), .CNT_SAT(1'b1)) u_sat (
    .sys_clk(sys_clk), .rst(rst),
    .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data),
    .m_valid(sat_m_valid), .m_ready(m_ready), .m_data(sat_m_data),
    .cnt_clr(cnt_clr), .beat_cnt(sat_beat_cnt)
  );

  hs_skid_slice #(.DATA_W(32), .CNT_W(16), .CNT_SAT(1'b0)) u_rand (
    .sys_clk(sys_clk), .rst(rst),
    .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
    .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data),
    .cnt_clr(r_cnt_clr), .beat_cnt(r_beat_cnt)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboards ----------------
  logic [7:0]  a_exp_q[$];
  logic [31:0] r_exp_q[$];
  logic        a_pend, r_pend, r_took;
  logic [7:0]  a_held;
  logic [31:0] r_held;
  int          r_pops;

  initial begin
    a_pend = 1'b0;
    r_pend = 1'b0;
    r_took = 1'b0;
    a_held = '0;
    r_held = '0;
    r_pops = 0;
  end

  // Sampled mid-cycle: inputs and outputs are settled for the coming edge.
  always @(negedge sys_clk) begin
    if (rst) begin
      a_exp_q.delete();
      a_pend = 1'b0;
    end else begin
      if (a_pend) begin
        check("a_hold_valid", 32'(s_valid), 32'(1));
        check("a_hold_data", 32'(s_data), 32'(a_held));
      end
      if (m_valid && m_ready) begin
        if (a_exp_q.size() == 0) check("a_pop_empty_q", 32'(m_data), 32'hFFFF_FFFF);
        else check("a_pop_data", 32'(m_data), 32'(a_exp_q.pop_front()));
      end
      if (s_valid && s_ready) a_exp_q.push_back(s_data);
      a_pend = s_valid && !s_ready;
      a_held = s_data;
    end
  end

  always @(negedge sys_clk) begin
    if (rst) begin
      r_exp_q.delete();
      r_pend = 1'b0;
      r_took = 1'b0;
      r_pops = 0;
    end else begin
      if (r_pend) begin
        check("r_hold_valid", 32'(r_s_valid), 32'(1));
        check("r_hold_data", r_s_data, r_held);
      end
      if (r_m_valid && r_m_ready) begin
        r_pops++;
        if (r_exp_q.size() == 0) check("r_pop_empty_q", r_m_data, ~r_m_data);
        else check("r_pop_data", r_m_data, r_exp_q.pop_front());
      end
      r_took = r_s_valid && r_s_ready;
      if (r_took) r_exp_q.push_back(r_s_data);
      r_pend = r_s_valid && !r_s_ready;
      r_held = r_s_data;
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst;
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       clr;
    logic       emv;
    logic       esr;
    logic [7:0] emd;
    logic [2:0] ecnt;
    logic [2:0] escnt;
  } vec_t;

  vec_t vecs[$];

  // Inputs driven for the coming edge; expectations are the outputs seen just before it.
  task automatic add(input int r, input int sv, input int sd, input int mr, input int clr,
                     input int emv, input int esr, input int emd, input int ecnt, input int escnt);
    vec_t v;
    v.rst   = 1'(r);
    v.sv    = 1'(sv);
    v.sd    = 8'(sd);
    v.mr    = 1'(mr);
    v.clr   = 1'(clr);
    v.emv   = 1'(emv);
    v.esr   = 1'(esr);
    v.emd   = 8'(emd);
    v.ecnt  = 3'(ecnt);
    v.escnt = 3'(escnt);
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      check($sformatf("v%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].emv));
      check($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].esr));
      check($sformatf("v%0d_beat_cnt", i), 32'(beat_cnt), 32'(vecs[i].ecnt));
      check($sformatf("v%0d_sat_cnt", i), 32'(sat_beat_cnt), 32'(vecs[i].escnt));
      if (vecs[i].emv) check($sformatf("v%0d_m_data", i), 32'(m_data), 32'(vecs[i].emd));
      rst     = vecs[i].rst;
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      m_ready = vecs[i].mr;
      cnt_clr = vecs[i].clr;
      step();
    end
  endtask

  // ---------------- random driver ----------------
  task automatic run_random();
    int vbias;
    int rbias;
    int guard;
    for (int c = 0; c < 10000; c++) begin
      vbias = ((c / 1000) % 2 == 0) ? 60 : 95;
      rbias = ((c / 500) % 3 == 0) ? 20 : (((c / 500) % 3 == 1) ? 95 : 55);
      if (!r_s_valid || r_took) begin
        r_s_valid = ($urandom_range(0, 99) < vbias);
        r_s_data  = $urandom;
      end
      r_m_ready = ($urandom_range(0, 99) < rbias);
      if (c % 97 == 0) check("r_beat_cnt", 32'(r_beat_cnt), 32'(r_pops[15:0]));
      step();
    end
    guard = 0;
    r_m_ready = 1'b1;
    while ((r_s_valid || r_m_valid || r_exp_q.size() != 0) && guard < 50) begin
      if (r_took) r_s_valid = 1'b0;
      step();
      guard++;
    end
    check("r_drain_timeout", 32'(guard < 50), 32'(1));
    check("r_final_cnt", 32'(r_beat_cnt), 32'(r_pops[15:0]));
    check("r_final_q_empty", 32'(r_exp_q.size()), 32'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'hEE;
    m_ready   = 1'b0;
    cnt_clr   = 1'b0;
    r_s_valid = 1'b0;
    r_s_data  = '0;
    r_m_ready = 1'b0;
    r_cnt_clr = 1'b0;

    // Reset then stream (the beat offered during reset must not be captured).
    add(0, 1, 'h10, 1, 0,  0, 1, 'h00, 0, 0);
    add(0, 1, 'h11, 1, 0,  1, 1, 'h10, 0, 0);
    add(0, 1, 'h12, 1, 0,  1, 1, 'h11, 1, 1);
    add(0, 1, 'h13, 1, 0,  1, 1, 'h12, 2, 2);
    add(0, 0, 'h00, 1, 0,  1, 1, 'h13, 3, 3);
    // Backpressure and skid.
    add(0, 1, 'hA1, 0, 0,  0, 1, 'h00, 4, 4);
    add(0, 1, 'hA2, 0, 0,  1, 1, 'hA1, 4, 4);
    add(0, 1, 'hA3, 0, 0,  1, 0, 'hA1, 4, 4);
    add(0, 1, 'hA3, 0, 0,  1, 0, 'hA1, 4, 4);
    add(0, 1, 'hA3, 1, 0,  1, 0, 'hA1, 4, 4);
    add(0, 1, 'hA3, 1, 0,  1, 1, 'hA2, 5, 5);
    add(0, 0, 'h00, 1, 0,  1, 1, 'hA3, 6, 6);
    add(0, 0, 'h00, 0, 1,  0, 1, 'h00, 7, 7);
    // Alternating ready: three pops, last beat left in the slice.
    add(0, 1, 'hB0, 0, 0,  0, 1, 'h00, 0, 0);
    add(0, 1, 'hB1, 0, 0,  1, 1, 'hB0, 0, 0);
    add(0, 1, 'hB2, 1, 0,  1, 0, 'hB0, 0, 0);
    add(0, 1, 'hB2, 0, 0,  1, 1, 'hB1, 1, 1);
    add(0, 1, 'hB3, 0, 0,  1, 0, 'hB1, 1, 1);
    add(0, 1, 'hB3, 1, 0,  1, 0, 'hB1, 1, 1);
    add(0, 1, 'hB3, 0, 0,  1, 1, 'hB2, 2, 2);
    add(0, 0, 'h00, 0, 0,  1, 0, 'hB2, 2, 2);
    add(0, 0, 'h00, 1, 0,  1, 0, 'hB2, 2, 2);
    add(0, 0, 'h00, 0, 0,  1, 1, 'hB3, 3, 3);
    // Reset while full, with handshakes offered in the reset cycle.
    add(0, 1, 'hC0, 0, 0,  1, 1, 'hB3, 3, 3);
    add(1, 1, 'hC1, 1, 0,  1, 0, 'hB3, 3, 3);
    add(0, 1, 'hD0, 0, 0,  0, 1, 'h00, 0, 0);
    add(0, 0, 'h00, 1, 0,  1, 1, 'hD0, 0, 0);
    // Counter modes: nine pops, then clear colliding with a pop.
    add(0, 1, 'h40, 1, 1,  0, 1, 'h00, 1, 1);
    for (int k = 0; k < 9; k++)
      add(0, 1, 'h41 + k, 1, 0,  1, 1, 'h40 + k, k % 8, (k > 7) ? 7 : k);
    add(0, 0, 'h00, 1, 1,  1, 1, 'h49, 1, 7);
    add(0, 1, 'h50, 0, 0,  0, 1, 'h00, 0, 0);
    add(0, 0, 'h00, 1, 0,  1, 1, 'h50, 0, 0);
    add(0, 0, 'h00, 0, 0,  0, 1, 'h00, 1, 1);

    repeat (2) @(posedge sys_clk);
    #1;
    run_table();
    check("a_final_q_empty", 32'(a_exp_q.size()), 32'(0));

    run_random();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
